pe_phase_sequencer: RTL and testbench
=====================================

PE_PHASE_SEQUENCER -- requirements
Module: pe_phase_sequencer

Interface
REQ-001 Parameter PASSES, default 1: number of 12-phase bidiagonalization passes per start; legal range 1..15.
REQ-002 Parameter PHASES, default 12: phases per pass; fixed at 12 for this revision.
REQ-003 clk  input  1  clock, rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  begin sequencing; sampled in IDLE only.
REQ-006 hold_i  input  1  stall request; freezes the sequence while high.
REQ-007 abort_i  input  1  synchronous abort to IDLE; has priority over all other inputs.
REQ-008 busy_o  output  1  high in RUN.
REQ-009 done_o  output  1  one-cycle pulse when the last pass completes.
REQ-010 phase_o  output  5  current phase, 0..11.
REQ-011 pass_o  output  4  current pass index, 0..PASSES-1.
REQ-012 pe_ce_o  output  1  PE pipeline clock enable: equals NOT (RUN and hold_i); 1 outside RUN.
REQ-013 pe0_valid_o, pe1_valid_o  output  2 each  per-lane PE valid.
REQ-014 pe0_scheme_o, pe1_scheme_o  output  2 each  scheme code: 0 complex-to-real, 1 complex-rotate, 2 real-nullify, 3 related-rotate.
REQ-015 rd_row_o  output  2  base row of the row pair (r, r+1) read from matrix storage.
REQ-016 rd_col_o  output  2  PE0 column; PE1 column is rd_col_o+1.
REQ-017 src_sel_o  output  1  PE operand source: 0 matrix storage, 1 PE output feedback.
REQ-018 swap_o  output  1  feed PE row-1 outputs to the X0/Y0 inputs and row-0 outputs to X1/Y1.
REQ-019 wb_en_o  output  1  write PE outputs back to storage this cycle.
REQ-020 wb_row_o, wb_col_o  output  2 each  write-back block base row and column; same encoding as read.
REQ-021 wb_swap_o  output  1  write PE X1/Y1 to row r and X0/Y0 to row r+1.

Function
REQ-022 States IDLE, RUN and DONE; encoded in a registered state plus registered 5-bit phase and 4-bit pass counters.
REQ-023 IDLE to RUN occurs on start_i=1, with phase=0 and pass=0 in the next cycle.
REQ-024 In RUN with hold_i=0, phase increments each cycle; at phase 11, phase wraps to 0 and pass increments.
REQ-025 When phase 11 of pass PASSES-1 completes, RUN goes to DONE; DONE lasts exactly one cycle with done_o=1, then returns to IDLE.
REQ-026 In RUN with hold_i=1, phase, pass and state hold; pe_ce_o=0, both valids=00, wb_en_o=0; all other outputs keep their decoded values.
REQ-027 Control outputs are decoded from registered phase and state, aligned with phase_o in the same cycle; outside RUN all control outputs are 0.
REQ-028 Phases 0-3 (issue): valids=11, src_sel=0, rd_row=2*(p>>1), rd_col=2*(p&1); pe0_scheme=0 if rd_col=0 else 1; pe1_scheme=1; wb_en=0.
REQ-029 Phases 4-7 (nullify): valids=11, src_sel=1; block k=p-4 gives rd_row=2*(k>>1) and rd_col=2*(k&1); pe0_scheme=2 if rd_col=0 else 3; pe1_scheme=3.
REQ-030 Phases 4-7 also write back: swap_o=1 for p=6,7; wb_en=1, wb_row/wb_col=block k, wb_swap=0.
REQ-031 Phases 8-11 (drain): valids=00; wb_en=1; block k=p-8 gives wb_row/wb_col per k; wb_swap=1 for p=10,11.
REQ-032 start_i in RUN or DONE is ignored, not queued.
REQ-033 abort_i=1 in any state forces IDLE next cycle with phase=0 and pass=0; done_o is not pulsed.
REQ-034 abort_i together with start_i in IDLE stays in IDLE.
REQ-035 hold_i in IDLE or DONE has no effect; DONE still lasts one cycle.
REQ-036 One uninterrupted run of P passes takes 12*P RUN cycles plus 1 DONE cycle.

Reset
REQ-037 While rst_n=0: state=IDLE, phase=0, pass=0, done_o=0, busy_o=0, pe_ce_o=1, all control outputs 0.
REQ-038 rst_n asserted mid-RUN aborts immediately; after release the block waits in IDLE for a new start_i.

Verification
REQ-039 PASSES=1, start_i pulse at cycle 0 -> busy_o cycles 1-12, phase_o 0..11, done_o pulse at cycle 13, IDLE at cycle 14.
REQ-040 Per-phase decode check -> p=0: pe0_scheme=0, rd=(0,0); p=5: pe0_scheme=3, src_sel=1, wb=(0,2); p=6: swap_o=1, wb=(2,0); p=10: wb_swap=1, wb=(2,0), valids=00.
REQ-041 hold_i high for 3 cycles at phase 5 -> phase_o stays 5, pe_ce_o=0, valids=00, wb_en=0; sequence resumes at 6; done_o is delayed by 3 cycles.
REQ-042 PASSES=3 -> pass_o steps 0,1,2 at phase wraps; done_o is pulsed once, 37 cycles after start.
REQ-043 abort_i at phase 7, plus start_i asserted during RUN -> IDLE next cycle, no done_o, the extra start is ignored; a fresh start restarts at phase 0.
REQ-044 rst_n pulsed low at phase 9 -> all outputs match REQ-037 asynchronously; the block stays in IDLE after release.

Source files
------------

// File: rtl/pe_phase_sequencer_if.sv
// Control bundle between the phase sequencer (slave) and whoever starts it and
// consumes the decoded PE / storage controls (master).
interface pe_phase_sequencer_if;
    logic       start_i;
    logic       hold_i;
    logic       abort_i;
    logic       busy_o;
    logic       done_o;
    logic [4:0] phase_o;
    logic [3:0] pass_o;
    logic       pe_ce_o;
    logic [1:0] pe0_valid_o;
    logic [1:0] pe1_valid_o;
    logic [1:0] pe0_scheme_o;
    logic [1:0] pe1_scheme_o;
    logic [1:0] rd_row_o;
    logic [1:0] rd_col_o;
    logic       src_sel_o;
    logic       swap_o;
    logic       wb_en_o;
    logic [1:0] wb_row_o;
    logic [1:0] wb_col_o;
    logic       wb_swap_o;

    modport slave (
        input  start_i, hold_i, abort_i,
        output busy_o, done_o, phase_o, pass_o, pe_ce_o,
        output pe0_valid_o, pe1_valid_o, pe0_scheme_o, pe1_scheme_o,
        output rd_row_o, rd_col_o, src_sel_o, swap_o,
        output wb_en_o, wb_row_o, wb_col_o, wb_swap_o
    );

    modport master (
        output start_i, hold_i, abort_i,
        input  busy_o, done_o, phase_o, pass_o, pe_ce_o,
        input  pe0_valid_o, pe1_valid_o, pe0_scheme_o, pe1_scheme_o,
        input  rd_row_o, rd_col_o, src_sel_o, swap_o,
        input  wb_en_o, wb_row_o, wb_col_o, wb_swap_o
    );
endinterface

// File: rtl/pe_phase_sequencer.sv
// Sequences the 12-phase issue / nullify / drain schedule of a two-PE
// bidiagonalization array over PASSES passes and decodes per-phase controls.
module pe_phase_sequencer #(
    parameter int unsigned PASSES = 1,
    parameter int unsigned PHASES = 12
) (
    input logic                 clk,
    input logic                 rst_n,
    pe_phase_sequencer_if.slave ctrl_io
);

    localparam logic [4:0] LastPhase = 5'(PHASES - 1);
    localparam logic [3:0] LastPass  = 4'(PASSES - 1);

    localparam logic [1:0] SchToReal  = 2'd0;
    localparam logic [1:0] SchRotate  = 2'd1;
    localparam logic [1:0] SchNullify = 2'd2;
    localparam logic [1:0] SchRelated = 2'd3;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e     state_q;
    logic [4:0] phase_q;
    logic [3:0] pass_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            phase_q <= '0;
            pass_q  <= '0;
        end else if (ctrl_io.abort_i) begin
            state_q <= StIdle;
            phase_q <= '0;
            pass_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ctrl_io.start_i) begin
                        state_q <= StRun;
                        phase_q <= '0;
                        pass_q  <= '0;
                    end
                end
                StRun: begin
                    if (!ctrl_io.hold_i) begin
                        if (phase_q == LastPhase) begin
                            phase_q <= '0;
                            if (pass_q == LastPass) begin
                                state_q <= StDone;
                                pass_q  <= '0;
                            end else begin
                                pass_q <= pass_q + 4'd1;
                            end
                        end else begin
                            phase_q <= phase_q + 5'd1;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    logic       run;
    logic [1:0] blk;
    logic [1:0] blk_row;
    logic [1:0] blk_col;

    assign run     = (state_q == StRun);
    // Each 4-phase group walks the 2x2 grid of blocks in row-major order.
    assign blk     = phase_q[1:0];
    assign blk_row = {blk[1], 1'b0};
    assign blk_col = {blk[0], 1'b0};

    assign ctrl_io.busy_o  = run;
    assign ctrl_io.done_o  = (state_q == StDone);
    assign ctrl_io.phase_o = phase_q;
    assign ctrl_io.pass_o  = pass_q;
    assign ctrl_io.pe_ce_o = !(run && ctrl_io.hold_i);

    always_comb begin
        ctrl_io.pe0_valid_o  = '0;
        ctrl_io.pe1_valid_o  = '0;
        ctrl_io.pe0_scheme_o = '0;
        ctrl_io.pe1_scheme_o = '0;
        ctrl_io.rd_row_o     = '0;
        ctrl_io.rd_col_o     = '0;
        ctrl_io.src_sel_o    = 1'b0;
        ctrl_io.swap_o       = 1'b0;
        ctrl_io.wb_en_o      = 1'b0;
        ctrl_io.wb_row_o     = '0;
        ctrl_io.wb_col_o     = '0;
        ctrl_io.wb_swap_o    = 1'b0;
        if (run) begin
            if (phase_q < 5'd4) begin
                ctrl_io.pe0_valid_o  = 2'b11;
                ctrl_io.pe1_valid_o  = 2'b11;
                ctrl_io.rd_row_o     = blk_row;
                ctrl_io.rd_col_o     = blk_col;
                ctrl_io.pe0_scheme_o = blk[0] ? SchRotate : SchToReal;
                ctrl_io.pe1_scheme_o = SchRotate;
            end else if (phase_q < 5'd8) begin
                ctrl_io.pe0_valid_o  = 2'b11;
                ctrl_io.pe1_valid_o  = 2'b11;
                ctrl_io.src_sel_o    = 1'b1;
                ctrl_io.rd_row_o     = blk_row;
                ctrl_io.rd_col_o     = blk_col;
                ctrl_io.pe0_scheme_o = blk[0] ? SchRelated : SchNullify;
                ctrl_io.pe1_scheme_o = SchRelated;
                ctrl_io.swap_o       = blk[1];
                ctrl_io.wb_en_o      = 1'b1;
                ctrl_io.wb_row_o     = blk_row;
                ctrl_io.wb_col_o     = blk_col;
            end else if (phase_q < 5'd12) begin
                ctrl_io.wb_en_o      = 1'b1;
                ctrl_io.wb_row_o     = blk_row;
                ctrl_io.wb_col_o     = blk_col;
                ctrl_io.wb_swap_o    = blk[1];
            end
            // A stall only suppresses side effects; addresses and schemes stay put.
            if (ctrl_io.hold_i) begin
                ctrl_io.pe0_valid_o = '0;
                ctrl_io.pe1_valid_o = '0;
                ctrl_io.wb_en_o     = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pe_phase_sequencer.sv
// Directed bench: one PASSES=1 and one PASSES=3 sequencer on a shared clock/reset.
module tb_pe_phase_sequencer;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   ndone;
    int   dcyc;

    pe_phase_sequencer_if if1 ();
    pe_phase_sequencer_if if3 ();

    pe_phase_sequencer #(.PASSES(1)) dut1 (.clk(clk), .rst_n(rst_n), .ctrl_io(if1.slave));
    pe_phase_sequencer #(.PASSES(3)) dut3 (.clk(clk), .rst_n(rst_n), .ctrl_io(if3.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {v0, v1, s0, s1, rd_row, rd_col, src_sel, swap, wb_en, wb_row, wb_col, wb_swap}
    function automatic logic [19:0] dec1();
        return {if1.pe0_valid_o, if1.pe1_valid_o, if1.pe0_scheme_o, if1.pe1_scheme_o,
                if1.rd_row_o, if1.rd_col_o, if1.src_sel_o, if1.swap_o,
                if1.wb_en_o, if1.wb_row_o, if1.wb_col_o, if1.wb_swap_o};
    endfunction

    function automatic logic [19:0] dec3();
        return {if3.pe0_valid_o, if3.pe1_valid_o, if3.pe0_scheme_o, if3.pe1_scheme_o,
                if3.rd_row_o, if3.rd_col_o, if3.src_sel_o, if3.swap_o,
                if3.wb_en_o, if3.wb_row_o, if3.wb_col_o, if3.wb_swap_o};
    endfunction

    function automatic logic [19:0] exp_dec(input int p);
        case (p)
            0:  return {2'b11, 2'b11, 2'd0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
            1:  return {2'b11, 2'b11, 2'd1, 2'd1, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
            2:  return {2'b11, 2'b11, 2'd0, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
            3:  return {2'b11, 2'b11, 2'd1, 2'd1, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
            4:  return {2'b11, 2'b11, 2'd2, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0};
            5:  return {2'b11, 2'b11, 2'd3, 2'd3, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 2'd0, 2'd2, 1'b0};
            6:  return {2'b11, 2'b11, 2'd2, 2'd3, 2'd2, 2'd0, 1'b1, 1'b1, 1'b1, 2'd2, 2'd0, 1'b0};
            7:  return {2'b11, 2'b11, 2'd3, 2'd3, 2'd2, 2'd2, 1'b1, 1'b1, 1'b1, 2'd2, 2'd2, 1'b0};
            8:  return {2'b00, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0};
            9:  return {2'b00, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 1'b0};
            10: return {2'b00, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b1};
            11: return {2'b00, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 1'b1};
            default: return '0;
        endcase
    endfunction

    task automatic check_idle1(input string tag);
        check({tag, "_busy"}, 32'(if1.busy_o), 32'd0);
        check({tag, "_done"}, 32'(if1.done_o), 32'd0);
        check({tag, "_phase"}, 32'(if1.phase_o), 32'd0);
        check({tag, "_pass"}, 32'(if1.pass_o), 32'd0);
        check({tag, "_ce"}, 32'(if1.pe_ce_o), 32'd1);
        check({tag, "_dec"}, 32'(dec1()), 32'd0);
    endtask

    task automatic check_idle3(input string tag);
        check({tag, "_busy3"}, 32'(if3.busy_o), 32'd0);
        check({tag, "_phase3"}, 32'(if3.phase_o), 32'd0);
        check({tag, "_ce3"}, 32'(if3.pe_ce_o), 32'd1);
        check({tag, "_dec3"}, 32'(dec3()), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        {if1.start_i, if1.hold_i, if1.abort_i} = 3'b000;
        {if3.start_i, if3.hold_i, if3.abort_i} = 3'b000;
        #2;
        check_idle1("reset");
        check_idle3("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_idle1("post_reset");

        // Hold in IDLE has no effect on the clock enable.
        if1.hold_i = 1'b1;
        #1;
        check("idle_hold_ce", 32'(if1.pe_ce_o), 32'd1);
        if1.hold_i = 1'b0;

        // Single pass: busy cycles 1-12, done at 13, idle at 14.
        if1.start_i = 1'b1;
        tick();
        if1.start_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("t1_busy", 32'(if1.busy_o), 32'd1);
            check("t1_phase", 32'(if1.phase_o), 32'(i));
            check("t1_dec", 32'(dec1()), 32'(exp_dec(i)));
            check("t1_ce", 32'(if1.pe_ce_o), 32'd1);
            check("t1_nodone", 32'(if1.done_o), 32'd0);
            tick();
        end
        check("t1_done", 32'(if1.done_o), 32'd1);
        check("t1_done_busy", 32'(if1.busy_o), 32'd0);
        if1.hold_i = 1'b1;
        #1;
        check("t1_done_hold_ce", 32'(if1.pe_ce_o), 32'd1);
        check("t1_done_hold_dec", 32'(dec1()), 32'd0);
        tick();
        if1.hold_i = 1'b0;
        check_idle1("t1_after_done");

        // Three-cycle stall at phase 5 delays done by three cycles.
        if1.start_i = 1'b1;
        tick();
        if1.start_i = 1'b0;
        cyc = 1;
        repeat (5) begin
            tick();
            cyc++;
        end
        check("t2_phase5", 32'(if1.phase_o), 32'd5);
        if1.hold_i = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t2_hold_phase", 32'(if1.phase_o), 32'd5);
            check("t2_hold_ce", 32'(if1.pe_ce_o), 32'd0);
            check("t2_hold_busy", 32'(if1.busy_o), 32'd1);
            check("t2_hold_dec", 32'(dec1()),
                  32'({2'b00, 2'b00, 2'd3, 2'd3, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0}));
            tick();
            cyc++;
        end
        if1.hold_i = 1'b0;
        #1;
        check("t2_release_phase", 32'(if1.phase_o), 32'd5);
        check("t2_release_dec", 32'(dec1()), 32'(exp_dec(5)));
        check("t2_release_ce", 32'(if1.pe_ce_o), 32'd1);
        tick();
        cyc++;
        check("t2_resume_phase", 32'(if1.phase_o), 32'd6);
        while (!if1.done_o && cyc < 60) begin
            tick();
            cyc++;
        end
        check("t2_done_cycle", 32'(cyc), 32'd16);
        tick();
        check_idle1("t2_after_done");

        // Three passes on the second instance.
        if3.start_i = 1'b1;
        tick();
        if3.start_i = 1'b0;
        cyc   = 1;
        ndone = 0;
        dcyc  = 0;
        while (cyc < 60) begin
            if (if3.done_o) begin
                ndone++;
                dcyc = cyc;
            end
            if (cyc == 12) begin
                check("t3_c12_pass", 32'(if3.pass_o), 32'd0);
                check("t3_c12_phase", 32'(if3.phase_o), 32'd11);
            end
            if (cyc == 13) begin
                check("t3_c13_pass", 32'(if3.pass_o), 32'd1);
                check("t3_c13_phase", 32'(if3.phase_o), 32'd0);
            end
            if (cyc == 25) begin
                check("t3_c25_pass", 32'(if3.pass_o), 32'd2);
                check("t3_c25_phase", 32'(if3.phase_o), 32'd0);
            end
            if (cyc == 36) begin
                check("t3_c36_pass", 32'(if3.pass_o), 32'd2);
                check("t3_c36_phase", 32'(if3.phase_o), 32'd11);
                check("t3_c36_busy", 32'(if3.busy_o), 32'd1);
            end
            tick();
            cyc++;
        end
        check("t3_done_count", 32'(ndone), 32'd1);
        check("t3_done_cycle", 32'(dcyc), 32'd37);
        check_idle3("t3_end");

        // Abort at phase 7 with a stray start during RUN.
        if1.start_i = 1'b1;
        tick();
        if1.start_i = 1'b0;
        tick();
        tick();
        if1.start_i = 1'b1;
        tick();
        if1.start_i = 1'b0;
        check("t4_start_ignored", 32'(if1.phase_o), 32'd3);
        repeat (4) tick();
        check("t4_phase7", 32'(if1.phase_o), 32'd7);
        if1.abort_i = 1'b1;
        #1;
        check("t4_abort_sync", 32'(if1.busy_o), 32'd1);
        tick();
        if1.abort_i = 1'b0;
        check_idle1("t4_abort");
        for (int i = 0; i < 5; i++) begin
            check("t4_no_done", 32'(if1.done_o), 32'd0);
            check("t4_stay_idle", 32'(if1.busy_o), 32'd0);
            tick();
        end
        if1.abort_i = 1'b1;
        if1.start_i = 1'b1;
        tick();
        if1.abort_i = 1'b0;
        if1.start_i = 1'b0;
        check_idle1("t4_abort_start");
        if1.start_i = 1'b1;
        tick();
        if1.start_i = 1'b0;
        check("t4_restart_busy", 32'(if1.busy_o), 32'd1);
        check("t4_restart_phase", 32'(if1.phase_o), 32'd0);
        check("t4_restart_dec", 32'(dec1()), 32'(exp_dec(0)));

        // Asynchronous reset at phase 9.
        repeat (9) tick();
        check("t5_phase9", 32'(if1.phase_o), 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle1("t5_async_reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_idle1("t5_release");
        repeat (3) tick();
        check_idle1("t5_stays_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
